// File: rtl/motor_cmd_decoder.sv
// Motor command decoder: takes completed SPI words, decodes the command byte,
// updates per-motor PWM period registers and builds the SPI response word.
module motor_cmd_decoder #(
  parameter int DATA_W       = 32,
  parameter int N_MOTORS     = 24,
  parameter int PWM_W        = 11,
  parameter int PERIOD_RESET = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         spi_word,
  input  logic                      spi_ready,
  input  logic [7:0]                enc_count,
  input  logic                      enc_dir,
  output logic [N_MOTORS*PWM_W-1:0] motor_periods,
  output logic [PWM_W-1:0]          led_period,
  output logic [DATA_W-1:0]         resp_word,
  output logic                      busy,
  output logic                      cmd_done,
  output logic                      cmd_err
);

  typedef enum logic [1:0] {IDLE, CAPTURE, EXEC} state_e;

  localparam logic [PWM_W-1:0] PRST = PWM_W'(PERIOD_RESET);

  state_e              state_q;
  logic [2:0]          sync_q;
  logic [DATA_W-1:0]   word_q;       // snapshot of spi_word while it is still stable
  logic [DATA_W-1:0]   stage_q;      // word handed from IDLE to CAPTURE
  logic [DATA_W-1:0]   pend_word_q;  // word of the queued (pending) command
  logic [DATA_W-1:0]   cmd_q;        // command being executed
  logic                pending_q;
  logic                from_pend_q;
  logic [PWM_W-1:0]    per_q [N_MOTORS];
  logic [PWM_W-1:0]    led_q;
  logic [DATA_W-1:0]   resp_q;
  logic                done_q, err_q;

  logic                early_rise, evt;
  logic [7:0]          cmd_d, sel_d, addr_d;
  logic [PWM_W-1:0]    per_d;

  // sync_q[1] is the synchronized ready; sync_q[0] rising is used only to
  // qualify the data snapshot, because the SPI word may be replaced by the
  // next transfer before the fully synchronized edge is seen.
  assign early_rise = sync_q[0] & ~sync_q[1];
  assign evt        = sync_q[1] & ~sync_q[2];

  // Field decode of the executing command; a zero period is clamped to 1.
  always_comb begin
    cmd_d  = cmd_q[31:24];
    addr_d = cmd_q[23:16];
    sel_d  = cmd_q[18:11];
    per_d  = cmd_q[PWM_W-1:0];
    if (per_d == '0) per_d = PWM_W'(1);
  end

  // Synchronizer chain and word snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      word_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], spi_ready};
      if (early_rise) word_q <= spi_word;
    end
  end

  // Command FSM with pending slot, register file and registered pulses.
  // The pending slot stays occupied until its word has been captured, so an
  // event arriving before that point has nowhere to go and is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      from_pend_q <= 1'b0;
      stage_q     <= '0;
      pend_word_q <= '0;
      cmd_q       <= '0;
      led_q       <= PRST;
      resp_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int k = 0; k < N_MOTORS; k++) per_q[k] <= PRST;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (evt && pending_q) err_q <= 1'b1;
      if (evt && !pending_q && state_q != IDLE) begin
        pending_q   <= 1'b1;
        pend_word_q <= word_q;
      end
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            from_pend_q <= 1'b1;
            state_q     <= CAPTURE;
          end else if (evt) begin
            from_pend_q <= 1'b0;
            stage_q     <= word_q;
            state_q     <= CAPTURE;
          end
        end
        CAPTURE: begin
          cmd_q <= from_pend_q ? pend_word_q : stage_q;
          if (from_pend_q) pending_q <= 1'b0;
          state_q <= EXEC;
        end
        EXEC: begin
          case (cmd_d)
            8'h00: begin
              if (int'(sel_d) < N_MOTORS) begin
                for (int k = 0; k < N_MOTORS; k++)
                  if (sel_d == 8'(k)) per_q[k] <= per_d;
                led_q  <= per_d;
                done_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
            8'h01: begin
              if (addr_d == 8'h00) begin
                resp_q <= DATA_W'({enc_dir, enc_count});
                done_q <= 1'b1;
              end else begin
                resp_q <= '0;
                err_q  <= 1'b1;
              end
            end
            default: err_q <= 1'b1;
          endcase
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_MOTORS; k++) begin : g_flat
    assign motor_periods[k*PWM_W +: PWM_W] = per_q[k];
  end

  assign led_period = led_q;
  assign resp_word  = resp_q;
  assign busy       = (state_q != IDLE);
  assign cmd_done   = done_q;
  assign cmd_err    = err_q;

endmodule

// File: tb/tb_motor_cmd_decoder.sv
// Directed bench for motor_cmd_decoder with a pulse-driven scoreboard.
module tb_motor_cmd_decoder;
  localparam int DW = 32;
  localparam int NM = 24;
  localparam int PW = 11;
  localparam int FW = NM*PW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] spi_word = '0;
  logic          spi_ready = 1'b0;
  logic [7:0]    enc_count = '0;
  logic          enc_dir = 1'b0;
  logic [FW-1:0] motor_periods;
  logic [PW-1:0] led_period;
  logic [DW-1:0] resp_word;
  logic          busy, cmd_done, cmd_err;

  motor_cmd_decoder #(.DATA_W(DW), .N_MOTORS(NM), .PWM_W(PW), .PERIOD_RESET(1)) dut (
    .clk(clk), .reset(reset), .spi_word(spi_word), .spi_ready(spi_ready),
    .enc_count(enc_count), .enc_dir(enc_dir), .motor_periods(motor_periods),
    .led_period(led_period), .resp_word(resp_word), .busy(busy),
    .cmd_done(cmd_done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    bit            chk_regs;
    logic [FW-1:0] flat;
    logic [PW-1:0] led;
    logic [DW-1:0] resp;
  } exp_t;

  exp_t          done_q[$];
  exp_t          err_q[$];
  logic [PW-1:0] m_per [NM];
  logic [PW-1:0] m_led;
  logic [DW-1:0] m_resp;
  int            n_assert = 0;
  int            n_fail = 0;
  int            pulses = 0;

  function automatic logic [FW-1:0] flat_model();
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NM; k++) f[k*PW +: PW] = m_per[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NM; k++) m_per[k] = PW'(1);
    m_led  = PW'(1);
    m_resp = '0;
  endtask

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_flat"}, motor_periods, flat_model());
    chk({tag, "_led"}, FW'(led_period), FW'(m_led));
    chk({tag, "_resp"}, FW'(resp_word), FW'(m_resp));
  endtask

  task automatic check_entry(input exp_t e, input string kind);
    if (e.chk_regs) begin
      chk({e.tag, kind, "_flat"}, motor_periods, e.flat);
      chk({e.tag, kind, "_led"}, FW'(led_period), FW'(e.led));
      chk({e.tag, kind, "_resp"}, FW'(resp_word), FW'(e.resp));
    end else begin
      chk({e.tag, kind, "_busy"}, FW'(busy), FW'(1));
    end
  endtask

  // One clock; any output pulse pops the matching scoreboard queue.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (cmd_done) begin
      pulses++;
      if (done_q.size() == 0) chk("spurious_done", FW'(cmd_done), FW'(0));
      else begin e = done_q.pop_front(); check_entry(e, "_done"); end
    end
    if (cmd_err) begin
      pulses++;
      if (err_q.size() == 0) chk("spurious_err", FW'(cmd_err), FW'(0));
      else begin e = err_q.pop_front(); check_entry(e, "_err"); end
    end
  endtask

  task automatic push(input string tag, input bit ok, input bit regs);
    exp_t e;
    e.tag = tag; e.chk_regs = regs; e.flat = flat_model(); e.led = m_led; e.resp = m_resp;
    if (ok) done_q.push_back(e); else err_q.push_back(e);
  endtask

  task automatic sb_empty(input string tag);
    chk({tag, "_done_left"}, FW'(done_q.size()), FW'(0));
    chk({tag, "_err_left"}, FW'(err_q.size()), FW'(0));
  endtask

  // Single transfer: model already updated by caller; checks 5-clock latency.
  task automatic send(input logic [DW-1:0] w, input string tag, input bit ok);
    int lat, p0;
    push(tag, ok, 1'b1);
    spi_word  = w;
    spi_ready = 1'b1;
    p0  = pulses;
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) spi_ready = 1'b0;
      if (lat == 99 && pulses != p0) lat = i;
    end
    chk({tag, "_latency"}, FW'(lat), FW'(5));
    chk({tag, "_idle"}, FW'(busy), FW'(0));
    chk_state({tag, "_after"});
    sb_empty(tag);
  endtask

  initial begin
    model_reset();
    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_state("rst");
    chk("rst_busy", FW'(busy), FW'(0));
    chk("rst_pulses", FW'({cmd_done, cmd_err}), FW'(0));
    reset = 1'b1;
    repeat (10) tick();
    chk_state("rst_idle10");
    chk("rst_idle10_busy", FW'(busy), FW'(0));

    // Motor write sel 3 period 1001
    m_per[3] = PW'(1001); m_led = PW'(1001);
    send(32'h0000_1BE9, "t2_sel3", 1'b1);

    // Out-of-range select, zero-period clamp, top valid select
    send(32'h0000_C064, "t3_sel24", 1'b0);
    m_per[3] = PW'(1); m_led = PW'(1);
    send(32'h0000_1800, "t3_clamp", 1'b1);
    m_per[23] = PW'(2047); m_led = PW'(2047);
    send(32'h0000_BFFF, "t3_sel23", 1'b1);

    // Data read, unknown command holds response, bad address clears it
    enc_count = 8'h5A; enc_dir = 1'b1;
    m_resp = 32'h0000_015A;
    send(32'h0100_0000, "t4_read", 1'b1);
    send(32'h7F00_1BE9, "t4_badcmd", 1'b0);
    m_resp = '0;
    send(32'h0105_0000, "t4_badaddr", 1'b0);

    // Three transfers two clocks apart: two executed, third dropped
    m_per[0] = PW'(100); m_led = PW'(100);
    push("t5_w0", 1'b1, 1'b1);
    spi_word = 32'h0000_0064; spi_ready = 1'b1;
    tick(); spi_ready = 1'b0;
    tick();
    m_per[1] = PW'(200); m_led = PW'(200);
    push("t5_w1", 1'b1, 1'b1);
    spi_word = 32'h0000_08C8; spi_ready = 1'b1;
    tick(); spi_ready = 1'b0;
    tick();
    push("t5_drop", 1'b0, 1'b0);
    spi_word = 32'h0000_112C; spi_ready = 1'b1;
    tick(); spi_ready = 1'b0;
    repeat (12) tick();
    chk_state("t5_final");
    chk("t5_reg2", FW'(motor_periods[2*PW +: PW]), FW'(1));
    sb_empty("t5");

    // Reset during CAPTURE of a sel 5 write
    spi_word = 32'h0000_29F4; spi_ready = 1'b1;
    tick(); spi_ready = 1'b0;
    tick(); tick();
    chk("t6_busy_before", FW'(busy), FW'(1));
    reset = 1'b0;
    model_reset();
    repeat (3) tick();
    reset = 1'b1;
    repeat (8) tick();
    chk_state("t6_after");
    chk("t6_reg5", FW'(motor_periods[5*PW +: PW]), FW'(1));
    chk("t6_busy", FW'(busy), FW'(0));
    sb_empty("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
